// File: rtl/connect4_pkg.sv
// Shared definitions for the connect-four column input path: column codes,
// board geometry, move FSM states and count-bus field extraction.
package connect4_pkg;

    localparam logic [3:0] COL0_N   = 4'b1110;
    localparam logic [3:0] COL1_N   = 4'b1101;
    localparam logic [3:0] COL2_N   = 4'b1011;
    localparam logic [3:0] COL3_N   = 4'b0111;
    localparam logic [3:0] COL_NONE = 4'b1111;

    localparam logic [2:0] ROWS_DEFAULT = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RELEASE
    } move_state_t;

    // Height field of the column selected by an active-low one-hot code.
    function automatic logic [2:0] height_of(input logic [11:0] count, input logic [3:0] sel);
        logic [2:0] h;
        h = 3'd0;
        case (sel)
            COL0_N:  h = count[2:0];
            COL1_N:  h = count[5:3];
            COL2_N:  h = count[8:6];
            COL3_N:  h = count[11:9];
            default: h = 3'd0;
        endcase
        return h;
    endfunction

    // True when exactly one button is held down.
    function automatic logic is_press(input logic [3:0] code);
        logic p;
        p = 1'b0;
        case (code)
            COL0_N, COL1_N, COL2_N, COL3_N: p = 1'b1;
            default:                        p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/btn_debounce_timer.sv
// Saturating stable-cycle counter; done flags the last cycle of a CYCLES-long
// stable window. Shared by the press and release debounce phases.
module btn_debounce_timer #(
    parameter logic [15:0] CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic done
);
    localparam int W = $clog2(CYCLES) + 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 16'd1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LAST);

endmodule

// File: rtl/column_move_controller.sv
// Debounced column-button front end: issues one setup/strobe/hold move per
// physical press, rejects full columns and tracks the current player.
module column_move_controller
    import connect4_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [2:0]  ROWS            = ROWS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  btn_n,
    input  logic [11:0] count,
    output logic [3:0]  column,
    output logic        add,
    output logic        player,
    output logic        reject
);
    logic [3:0]  sync1_q;
    logic [3:0]  btn_s_q;
    move_state_t state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  column_q, column_d;
    logic        add_q, add_d;
    logic        player_q, player_d;
    logic        reject_q, reject_d;
    logic        timer_clear;
    logic        timer_inc;
    logic        timer_done;

    btn_debounce_timer #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .clear(timer_clear),
        .inc  (timer_inc),
        .done (timer_done)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        reject_d    = 1'b0;
        timer_clear = 1'b0;
        timer_inc   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (is_press(btn_s_q)) begin
                    state_d     = ST_DEBOUNCE;
                    sel_d       = btn_s_q;
                    timer_clear = 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (btn_s_q != sel_q) begin
                    state_d = ST_IDLE;
                end else if (timer_done) begin
                    // The count bus is only trusted at this single instant.
                    if (height_of(count, sel_q) < ROWS) begin
                        state_d = ST_SETUP;
                    end else begin
                        state_d     = ST_RELEASE;
                        reject_d    = 1'b1;
                        timer_clear = 1'b1;
                    end
                end else begin
                    timer_inc = 1'b1;
                end
            end
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: state_d = ST_HOLD;
            ST_HOLD: begin
                state_d     = ST_RELEASE;
                timer_clear = 1'b1;
            end
            ST_RELEASE: begin
                if (btn_s_q != COL_NONE) begin
                    timer_clear = 1'b1;
                end else if (timer_done) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        column_d = COL_NONE;
        if ((state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD)) begin
            column_d = sel_d;
        end
        add_d    = (state_d == ST_STROBE);
        player_d = player_q ^ (state_q == ST_STROBE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= COL_NONE;
            btn_s_q  <= COL_NONE;
            state_q  <= ST_IDLE;
            sel_q    <= COL_NONE;
            column_q <= COL_NONE;
            add_q    <= 1'b0;
            player_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            sync1_q  <= btn_n;
            btn_s_q  <= sync1_q;
            state_q  <= state_d;
            sel_q    <= sel_d;
            column_q <= column_d;
            add_q    <= add_d;
            player_q <= player_d;
            reject_q <= reject_d;
        end
    end

    assign column = column_q;
    assign add    = add_q;
    assign player = player_q;
    assign reject = reject_q;

endmodule

// File: tb/tb_column_move_controller.sv
// Scoreboard bench: stimulus predicts each move outcome from the game rules,
// a negedge monitor pops and checks whenever add or reject fires.
module tb_column_move_controller;

    localparam logic [15:0] DEB = 16'd4;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [3:0]  btn_i;
    logic [11:0] count_i;
    logic [3:0]  column_o;
    logic        add_o;
    logic        player_o;
    logic        reject_o;

    column_move_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .ROWS           (3'd6)
    ) dut (
        .clk   (clk),
        .reset (reset_i),
        .btn_n (btn_i),
        .count (count_i),
        .column(column_o),
        .add   (add_o),
        .player(player_o),
        .reject(reject_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_add;
        logic [3:0] code;
        bit         plyr;
        int         earliest;
        int         latest;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   player_m = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference rule: exactly one button down selects a column; the move is
    // accepted if that column holds fewer than six pieces, otherwise rejected.
    function automatic void predict(input logic [3:0] code, input logic [11:0] cnt, input int start);
        exp_t e;
        int idx;
        int h;
        if ($countones(~code) != 1) return;
        idx = 0;
        for (int i = 0; i < 4; i++) if (code[i] == 1'b0) idx = i;
        h = int'((cnt >> (3 * idx)) & 12'h7);
        e.is_add   = (h < 6);
        e.code     = code;
        e.plyr     = player_m;
        e.earliest = start + 2 + int'(DEB);
        e.latest   = start + 2 + int'(DEB) + 6;
        exp_q.push_back(e);
        if (e.is_add) player_m = ~player_m;
    endfunction

    // Monitor
    logic [3:0] prev_column = 4'hF;
    bit         prev_add = 1'b0;
    bit         hold_chk = 1'b0;
    logic [3:0] hold_code = 4'hF;

    always @(negedge clk) begin
        exp_t e;
        if (hold_chk) begin
            vectors++;
            if (column_o != hold_code) begin
                miscompares++;
                $display("FAIL hold_column: got %b expected %b", column_o, hold_code);
            end
            hold_chk = 1'b0;
        end
        if (add_o && reject_o) begin
            vectors++;
            miscompares++;
            $display("FAIL add_and_reject: both high at cycle %0d", cyc);
        end
        if (add_o || reject_o) begin
            vectors++;
            if (add_o && prev_add) begin
                miscompares++;
                $display("FAIL add_width: add high two cycles running at cycle %0d", cyc);
            end else if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: add=%b reject=%b column=%b at cycle %0d, none expected",
                         add_o, reject_o, column_o, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.is_add != add_o) begin
                    miscompares++;
                    $display("FAIL event_kind: got add=%b reject=%b expected add=%b", add_o, reject_o, e.is_add);
                end
                vectors++;
                if (player_o != e.plyr) begin
                    miscompares++;
                    $display("FAIL event_player: got %b expected %b", player_o, e.plyr);
                end
                vectors++;
                if (cyc < e.earliest || cyc > e.latest) begin
                    miscompares++;
                    $display("FAIL event_time: got cycle %0d expected %0d..%0d", cyc, e.earliest, e.latest);
                end
                if (add_o) begin
                    vectors++;
                    if (column_o != e.code || prev_column != e.code) begin
                        miscompares++;
                        $display("FAIL add_column: got %b (setup %b) expected %b", column_o, prev_column, e.code);
                    end
                    hold_chk  = 1'b1;
                    hold_code = e.code;
                end else begin
                    vectors++;
                    if (column_o != 4'hF) begin
                        miscompares++;
                        $display("FAIL reject_column: got %b expected 1111", column_o);
                    end
                end
            end
        end
        prev_column = column_o;
        prev_add    = add_o;
    end

    task automatic drain_check(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_%s: %0d expected events not seen, required 0", name, exp_q.size());
        end
        exp_q.delete();
        vectors++;
        if (player_o != player_m) begin
            miscompares++;
            $display("FAIL player_%s: got %b expected %b", name, player_o, player_m);
        end
    endtask

    task automatic press(input logic [3:0] code, input logic [11:0] cnt, input int hold, input string name);
        @(negedge clk);
        count_i = cnt;
        btn_i   = code;
        predict(code, cnt, cyc);
        repeat (hold) @(negedge clk);
        btn_i = 4'hF;
        repeat (20) @(negedge clk);
        $display("press %s: code=%b count=%h hold=%0d player=%b", name, code, cnt, hold, player_o);
        drain_check(name);
    endtask

    task automatic bounce_press(input logic [3:0] code, input logic [11:0] cnt, input string name);
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            btn_i = code;
            @(negedge clk);
            @(negedge clk);
            btn_i = 4'hF;
            @(negedge clk);
        end
        press(code, cnt, 20, name);
    endtask

    task automatic idle_check(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vectors++;
            if (column_o != 4'hF || add_o || reject_o || player_o) begin
                miscompares++;
                $display("FAIL %s: column=%b add=%b reject=%b player=%b expected 1111/0/0/0",
                         name, column_o, add_o, reject_o, player_o);
            end
        end
    endtask

    function automatic logic [3:0] col_code(input int idx);
        logic [3:0] c;
        c = 4'hF;
        c[idx] = 1'b0;
        return c;
    endfunction

    initial begin
        int kind;
        int idx;
        logic [3:0] c;
        logic [11:0] cnt;
        bit seen;

        reset_i = 1'b1;
        btn_i   = 4'hF;
        count_i = 12'h000;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        idle_check(20, "reset_idle");

        press(4'b1101, 12'h000, 20, "clean");
        bounce_press(4'b1011, 12'h000, "bounce");
        press(4'b0111, {3'd6, 9'd0}, 20, "full6");
        press(4'b0111, {3'd7, 9'd0}, 20, "full7");
        press(4'b0111, {3'd5, 9'd0}, 20, "height5");
        press(4'b1100, 12'h000, 20, "multi");
        press(4'b1110, 12'h000, 20, "after_multi");

        // Reset during SETUP: the pending move must never appear.
        @(negedge clk);
        count_i = 12'h000;
        btn_i   = 4'b1110;
        seen    = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (column_o != 4'hF) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL setup_timeout: column stayed 1111, required a move within 40 cycles");
        end
        reset_i  = 1'b1;
        btn_i    = 4'hF;
        player_m = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
        vectors++;
        if (column_o != 4'hF || add_o || player_o) begin
            miscompares++;
            $display("FAIL mid_reset: column=%b add=%b player=%b expected 1111/0/0", column_o, add_o, player_o);
        end
        $display("mid_reset: column=%b add=%b player=%b", column_o, add_o, player_o);
        idle_check(20, "post_reset_idle");

        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 3));
            idx  = int'($urandom_range(0, 3));
            cnt  = 12'($urandom);
            case (kind)
                0: press(col_code(idx), cnt, int'($urandom_range(12, 25)), "rand_clean");
                1: bounce_press(col_code(idx), cnt, "rand_bounce");
                2: begin
                    c = 4'($urandom);
                    while ($countones(~c) == 1) c = 4'($urandom);
                    press(c, cnt, 20, "rand_multi");
                end
                default: press(col_code(idx), {3'd6 + 3'($urandom_range(0, 1)), 9'($urandom)}, 15, "rand_edge");
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
        $fatal(1, "timeout");
    end

endmodule
